// File: rtl/tdm_pkg.sv
// Shared types and constants for the five-slot TDM demultiplexer.
package tdm_pkg;
   localparam int unsigned NUM_CH = 5;
   localparam int unsigned SLOT_W = 3;

   typedef logic [SLOT_W-1:0] slot_t;

   localparam slot_t LAST_SLOT = 3'd4;

   // Slot sequence 0..4 with wrap; codes 5..7 are never produced.
   function automatic slot_t next_slot(input slot_t s);
      return (s == LAST_SLOT) ? slot_t'(0) : slot_t'(s + slot_t'(1));
   endfunction
endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index tracker: advances on each accepted beat, resync forces slot 1.
module tdm_slot_counter
   import tdm_pkg::*;
(
   input  logic  i_CLK,
   input  logic  i_RST,
   input  logic  advance,
   input  logic  sof_resync,
   output slot_t slot,
   output logic  last
);

   // A resync beat is itself captured as slot 0, so the next beat lands in slot 1.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         slot <= '0;
      end else if (sof_resync) begin
         slot <= slot_t'(1);
      end else if (advance) begin
         slot <= next_slot(slot);
      end
   end

   assign last = (slot == LAST_SLOT);

endmodule

// File: rtl/tdm_demux_5.sv
// Five-channel TDM demultiplexer with frame-staged outputs.
// Optional o_ERR resync pulse is compiled in with TDM_DEMUX_ERR_EN.
module tdm_demux_5
   import tdm_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             i_CLK,
   input  logic             i_RST,
   input  logic [WIDTH-1:0] i_DATA,
   input  logic             i_VALID,
   input  logic             i_SOF,
   output logic [WIDTH-1:0] o_A,
   output logic [WIDTH-1:0] o_B,
   output logic [WIDTH-1:0] o_C,
   output logic [WIDTH-1:0] o_D,
   output logic [WIDTH-1:0] o_E,
   output logic             o_FRAME_VALID,
`ifdef TDM_DEMUX_ERR_EN
   output logic             o_ERR,
`endif
   output logic [2:0]       o_SLOT
);

   slot_t            slot;
   logic             last;
   logic             resync;
   logic             frame_done;
   logic [WIDTH-1:0] staging [NUM_CH];

   assign resync     = i_VALID & i_SOF & (slot != '0);
   assign frame_done = i_VALID & last & ~resync;

   tdm_slot_counter u_slot_counter (
      .i_CLK      (i_CLK),
      .i_RST      (i_RST),
      .advance    (i_VALID),
      .sof_resync (resync),
      .slot       (slot),
      .last       (last)
   );

   assign o_SLOT = slot;

   // Staging capture and whole-frame publish; the slot-4 beat bypasses staging.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         for (int i = 0; i < int'(NUM_CH); i++) begin
            staging[i] <= '0;
         end
         o_A           <= '0;
         o_B           <= '0;
         o_C           <= '0;
         o_D           <= '0;
         o_E           <= '0;
         o_FRAME_VALID <= 1'b0;
      end else begin
         o_FRAME_VALID <= frame_done;
         if (i_VALID) begin
            if (resync) begin
               staging[0] <= i_DATA;
            end else begin
               staging[slot] <= i_DATA;
            end
         end
         if (frame_done) begin
            o_A <= staging[0];
            o_B <= staging[1];
            o_C <= staging[2];
            o_D <= staging[3];
            o_E <= i_DATA;
         end
      end
   end

`ifdef TDM_DEMUX_ERR_EN
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         o_ERR <= 1'b0;
      end else begin
         o_ERR <= resync;
      end
   end
`endif

endmodule

// File: tb/tb_tdm_demux_5.sv
// Directed plus randomized bench for tdm_demux_5 against a frame-level model.
module tb_tdm_demux_5;
   localparam int unsigned WIDTH = 4;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] data;
   logic             valid;
   logic             sof;
   logic [WIDTH-1:0] a, b, c, d, e;
   logic             frame_valid;
   logic [2:0]       slot;
`ifdef TDM_DEMUX_ERR_EN
   logic             err;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state: where the next beat goes, the partial frame, the published frame.
   int               m_slot;
   logic [WIDTH-1:0] m_part [5];
   logic [WIDTH-1:0] m_out  [5];
   logic             m_fv;
   logic             m_err;

   tdm_demux_5 #(.WIDTH(WIDTH)) dut (
      .i_CLK         (clk),
      .i_RST         (rst),
      .i_DATA        (data),
      .i_VALID       (valid),
      .i_SOF         (sof),
      .o_A           (a),
      .o_B           (b),
      .o_C           (c),
      .o_D           (d),
      .o_E           (e),
      .o_FRAME_VALID (frame_valid),
`ifdef TDM_DEMUX_ERR_EN
      .o_ERR         (err),
`endif
      .o_SLOT        (slot)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_slot = 0;
      m_fv   = 1'b0;
      m_err  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         m_part[i] = '0;
         m_out[i]  = '0;
      end
   endtask

   task automatic model_edge(input logic v, input logic s, input logic [WIDTH-1:0] dt);
      m_fv  = 1'b0;
      m_err = 1'b0;
      if (v) begin
         if (s && m_slot != 0) begin
            m_part[0] = dt;
            m_slot    = 1;
            m_err     = 1'b1;
         end else begin
            m_part[m_slot] = dt;
            if (m_slot == 4) begin
               for (int i = 0; i < 5; i++) m_out[i] = m_part[i];
               m_fv   = 1'b1;
               m_slot = 0;
            end else begin
               m_slot = m_slot + 1;
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".A"}, 32'(a), 32'(m_out[0]));
      chk({tag, ".B"}, 32'(b), 32'(m_out[1]));
      chk({tag, ".C"}, 32'(c), 32'(m_out[2]));
      chk({tag, ".D"}, 32'(d), 32'(m_out[3]));
      chk({tag, ".E"}, 32'(e), 32'(m_out[4]));
      chk({tag, ".fv"}, 32'(frame_valid), 32'(m_fv));
      chk({tag, ".slot"}, 32'(slot), 32'(m_slot));
`ifdef TDM_DEMUX_ERR_EN
      chk({tag, ".err"}, 32'(err), 32'(m_err));
`endif
   endtask

   // Apply one cycle of input, let the edge happen, then compare away from the edge.
   task automatic step(input string tag, input logic v, input logic s, input logic [WIDTH-1:0] dt);
      valid = v;
      sof   = s;
      data  = dt;
      @(posedge clk);
      #1;
      model_edge(v, s, dt);
      check_all(tag);
   endtask

   task automatic frame(input string tag, input logic [WIDTH-1:0] d0, d1, d2, d3, d4);
      step(tag, 1'b1, 1'b1, d0);
      step(tag, 1'b1, 1'b0, d1);
      step(tag, 1'b1, 1'b0, d2);
      step(tag, 1'b1, 1'b0, d3);
      step(tag, 1'b1, 1'b0, d4);
   endtask

   initial begin
      rst   = 1'b1;
      valid = 1'b0;
      sof   = 1'b0;
      data  = '0;
      model_reset();
      #12;
      check_all("por");
      #4;
      rst = 1'b0;

      // Basic frame then an idle cycle: pulse must last exactly one cycle.
      frame("basic", 4'h1, 4'h2, 4'h3, 4'h4, 4'h5);
      step("basic_idle", 1'b0, 1'b0, 4'h0);

      // Gapped frame: slot holds at 2, outputs keep the previous frame.
      step("gap", 1'b1, 1'b1, 4'h6);
      step("gap", 1'b1, 1'b0, 4'h7);
      for (int i = 0; i < 3; i++) step("gap_idle", 1'b0, 1'b0, 4'hF);
      step("gap", 1'b1, 1'b0, 4'h8);
      step("gap", 1'b1, 1'b0, 4'h9);
      step("gap", 1'b1, 1'b0, 4'hA);

      // Back-to-back frames with slot wrap.
      frame("b2b1", 4'h1, 4'h2, 4'h3, 4'h4, 4'h5);
      frame("b2b2", 4'hA, 4'hB, 4'hC, 4'hD, 4'hE);

      // Resync: 7,8 discarded, SOF with 9 restarts the frame.
      step("rsy", 1'b1, 1'b0, 4'h7);
      step("rsy", 1'b1, 1'b0, 4'h8);
      step("rsy_sof", 1'b1, 1'b1, 4'h9);
      step("rsy", 1'b1, 1'b0, 4'hA);
      step("rsy", 1'b1, 1'b0, 4'hB);
      step("rsy", 1'b1, 1'b0, 4'hC);
      step("rsy", 1'b1, 1'b0, 4'hD);
      chk("rsy_frame.A", 32'(a), 32'h9);
      chk("rsy_frame.E", 32'(e), 32'hD);

      // SOF without VALID at slot 3 is ignored.
      step("isof", 1'b1, 1'b1, 4'h1);
      step("isof", 1'b1, 1'b0, 4'h2);
      step("isof", 1'b1, 1'b0, 4'h3);
      step("isof_nv", 1'b0, 1'b1, 4'h5);
      chk("isof_slot3", 32'(slot), 32'd3);
      step("isof", 1'b1, 1'b0, 4'h4);
      step("isof", 1'b1, 1'b0, 4'h6);

      // Asynchronous reset after two beats, checked before any clock edge.
      step("mrst", 1'b1, 1'b1, 4'h3);
      step("mrst", 1'b1, 1'b0, 4'h4);
      valid = 1'b0;
      sof   = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all("mrst_async");
      @(posedge clk);
      #1;
      check_all("mrst_held");
      rst = 1'b0;
      frame("post_rst", 4'hC, 4'h0, 4'hF, 4'hE, 4'h1);

      // Randomized traffic with occasional gaps and SOF markers.
      for (int n = 0; n < 400; n++) begin
         step("rand", ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
              WIDTH'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tdm_demux_5.md
# tdm_demux_5

Time-division demultiplexer: takes one WIDTH-bit stream carrying five interleaved channels (slot 0..4, A..E) and distributes each beat to its own output channel. This is the receive-side counterpart of the 5:1 channel selector. Incoming beats are collected into a staging buffer, and all five outputs are updated together once per completed frame. Sits between the serial link and the per-channel consumers.

## Interface

- WIDTH, 4, bit width of each channel / beat
- i_CLK  input  1  clock; all state changes on the rising edge
- i_RST  input  1  asynchronous, active-high reset
- i_DATA  input  WIDTH  incoming beat
- i_VALID  input  1  i_DATA is valid this cycle
- i_SOF  input  1  start-of-frame marker; qualified by i_VALID
- o_A, o_B, o_C, o_D, o_E  output  WIDTH  channel outputs, slots 0..4, held between frames
- o_FRAME_VALID  output  1  one-cycle pulse when o_A..o_E carry a new frame
- o_SLOT  output  3  slot index the next valid beat is written to (0..4)
- o_ERR  output  1  one-cycle sync-error pulse; present only with TDM_DEMUX_ERR_EN

## Operation

- **Reset** (asynchronous, active-high). While i_RST is high:
  - o_A..o_E, staging buffer = 0
  - o_SLOT = 0
  - o_FRAME_VALID = 0, o_ERR = 0
- **Slot counter**, 3 bits, range 0..4:
  - Advances only on cycles with i_VALID=1.
  - Wraps from 4 to 0.
  - Codes 5..7 are never reachable.
- **Beat capture.** Each beat with i_VALID=1 writes i_DATA into staging[slot].
- **Frame completion.** When the slot-4 beat is captured:
  - The staging contents, including that beat, are copied to o_A..o_E on the same edge.
  - o_FRAME_VALID goes high for exactly that following cycle.
- **Between frames.** Outputs hold their last complete frame; a partial frame is never visible.
- **i_VALID=0.** No state changes.
- **i_SOF.** Optional at slot 0, and ignored unless i_VALID=1.
  - With i_VALID=1 at slot 0: normal capture.
  - With i_VALID=1 at slot != 0 (resync): the partial frame is discarded (no output update). The beat is captured as slot 0 and the counter goes to 1.
- **Reset mid-frame.** The partial frame is lost and outputs return to 0.

## Timing

- Latency, slot-4 beat to output: 1 cycle. The output register updates on the same edge that captures the beat.
- Throughput: one beat per cycle, so back-to-back frames give an o_FRAME_VALID pulse every 5 cycles.
- o_SLOT is registered and reflects the state after the last edge.
- o_ERR, when compiled in, is registered and pulses in the cycle after the offending edge.
- No back-pressure: the block always accepts i_VALID beats.

## Configuration

- **TDM_DEMUX_ERR_EN defined:**
  - o_ERR exists.
  - A resync event (i_SOF with i_VALID at slot != 0) pulses o_ERR for 1 cycle.
  - o_ERR is 0 at reset.
- **Not defined:**
  - o_ERR and its register are absent.
  - Resync still happens silently, with identical data behaviour.

## Structure

- **Shared package tdm_pkg:**
  - NUM_CH = 5
  - SLOT_W = 3
  - LAST_SLOT = 3'd4
  - slot_t typedef (logic [SLOT_W-1:0])
- **Sub-module tdm_slot_counter:**
  - Inputs: i_CLK, i_RST, advance, sof_resync.
  - Outputs: slot, last (slot==LAST_SLOT).
- The top level holds the staging array, output registers and the error flag.

## Test plan

- **Reset:** assert i_RST mid-frame (after 2 beats), release.
  - Expected: all outputs 0 and o_SLOT=0 immediately, asynchronously.
  - The next 5 beats form a clean frame.
- **Basic frame:** i_SOF+beats 1,2,3,4,5 on consecutive cycles.
  - Expected: next cycle o_A..o_E = 1,2,3,4,5 and o_FRAME_VALID=1 for exactly 1 cycle.
- **Gapped input:** same frame with i_VALID=0 for 3 cycles between beats 2 and 3.
  - Expected: identical outputs; o_SLOT holds at 2 during the gap.
  - Outputs keep the previous frame until the slot-4 beat.
- **Back-to-back frames:** frames {1..5} then {A,B,C,D,E} (hex), continuous.
  - Expected: two o_FRAME_VALID pulses 5 cycles apart, second showing A..E.
  - Slot wraps 4 to 0.
- **Resync:** after frame {1..5}, send 7,8 then i_SOF with 9, then beats A,B,C,D.
  - Expected: no update for 7,8; next frame is 9,A,B,C,D.
  - With TDM_DEMUX_ERR_EN: o_ERR=1 for 1 cycle after the SOF edge; without the macro, the port is absent.
- **Ignored SOF:** i_SOF=1 with i_VALID=0 at slot 3.
  - Expected: no resync, no o_ERR; o_SLOT stays 3.
